// File: rtl/mem_line_arbiter_pkg.sv
// Shared constants and types for the cache-to-memory line arbiter.
package mem_line_arbiter_pkg;
  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int LATENCY    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic                 port;
    logic                 write;
    logic [WORD_SIZE-1:0] addr;
  } grant_t;

  function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] a);
    return {a[WORD_SIZE-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/mem_rr_grant.sv
// Two-requester round-robin pick; last_grant only advances when the pick is taken.
module mem_rr_grant
  import mem_line_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output logic grant
);
  logic last_grant;

  always_comb begin
    grant = PORT_I;
    if (i_req && d_req) grant = ~last_grant;
    else if (d_req)     grant = PORT_D;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_grant <= PORT_I;
    else if (take) last_grant <= grant;
  end
endmodule

// File: rtl/mem_line_arbiter.sv
// Serialises I-cache fills and D-cache fills/write-backs onto one fixed-latency line port.
module mem_line_arbiter #(
  parameter int WORD_SIZE  = mem_line_arbiter_pkg::WORD_SIZE,
  parameter int LINE_WORDS = mem_line_arbiter_pkg::LINE_WORDS,
  parameter int LATENCY    = mem_line_arbiter_pkg::LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_read,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] i_rdata,
  output logic                            i_done,
  input  logic                            d_read,
  input  logic                            d_write,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
  output logic [WORD_SIZE*LINE_WORDS-1:0] d_rdata,
  output logic                            d_done,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata
);
  import mem_line_arbiter_pkg::*;

  state_e                          state, state_nx;
  logic [2:0]                      count;
  grant_t                          req_q;
  logic [WORD_SIZE*LINE_WORDS-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic                            d_req, any_req, take, gnt_port, last_cyc;

  assign d_req    = d_read | d_write;
  assign any_req  = i_read | d_req;
  assign take     = (state == IDLE) && any_req;
  assign last_cyc = (state == ACCESS) && (count == 3'(LATENCY));

  mem_rr_grant u_rr (
    .clk   (clk),
    .reset (reset),
    .i_req (i_read),
    .d_req (d_req),
    .take  (take),
    .grant (gnt_port)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (last_cyc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 3'd0;
      req_q     <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        // read+write together from D is treated as a write
        req_q <= '{port:  gnt_port,
                   write: (gnt_port == PORT_D) && d_write,
                   addr:  line_align(gnt_port == PORT_D ? d_addr : i_addr)};
        wdata_q <= d_wdata;
        count   <= 3'd1;
      end else if (last_cyc) begin
        count <= 3'd0;
        if (!req_q.write) begin
          if (req_q.port == PORT_I) i_rdata_q <= mem_rdata;
          else                      d_rdata_q <= mem_rdata;
        end
      end else if (state == ACCESS) begin
        count <= count + 3'd1;
      end
    end
  end

  assign mem_read  = (state == ACCESS) && !req_q.write;
  assign mem_write = (state == ACCESS) &&  req_q.write;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = wdata_q;
  assign i_done    = (state == DONE) && (req_q.port == PORT_I);
  assign d_done    = (state == DONE) && (req_q.port == PORT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with LATENCY=4.
module tb_mem_line_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write;
  logic [15:0] i_addr, d_addr, mem_addr;
  logic [63:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic        i_done, d_done, mem_read, mem_write;

  int checks = 0;
  int errors = 0;
  int both_done = 0;

  always #5 clk = ~clk;

  mem_line_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(negedge clk) if (i_done && d_done) both_done++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Steps until a done pulse (bounded), tallying strobe cycles.
  task automatic run_access(input int max, output int rd_n, output int wr_n,
                            output int i_at, output int d_at,
                            output logic [15:0] addr_seen, output bit unstable);
    logic [63:0] wd_seen;
    rd_n = 0; wr_n = 0; i_at = -1; d_at = -1; addr_seen = '0; unstable = 0; wd_seen = '0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (mem_read || mem_write) begin
        if (rd_n + wr_n == 0) begin addr_seen = mem_addr; wd_seen = mem_wdata; end
        else if (mem_addr !== addr_seen || mem_wdata !== wd_seen) unstable = 1;
      end
      if (mem_read)  rd_n++;
      if (mem_write) wr_n++;
      if (i_done) i_at = k;
      if (d_done) d_at = k;
      if (i_done || d_done) break;
    end
  endtask

  int rd_n, wr_n, i_at, d_at, extra_rd;
  logic [15:0] addr_seen;
  bit unstable;

  initial begin
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #2; step(); step();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    reset = 1'b0;

    // 1: lone I fill
    i_addr = 16'h0027; i_read = 1; mem_rdata = 64'h1111_2222_3333_4444;
    run_access(20, rd_n, wr_n, i_at, d_at, addr_seen, unstable);
    chk("t1_rd_cycles", rd_n, 4);
    chk("t1_wr_cycles", wr_n, 0);
    chk("t1_done_at", i_at, 5);
    chk("t1_addr", addr_seen, 16'h0024);
    chk("t1_stable", unstable, 0);
    chk("t1_i_rdata", i_rdata, 64'h1111_2222_3333_4444);
    i_read = 0;
    step();
    chk("t1_done_pulse", i_done, 0);

    // 3: simultaneous fills; D wins first since I was granted last
    i_addr = 16'h0040; d_addr = 16'h0083; mem_rdata = 64'h5555_6666_7777_8888;
    i_read = 1; d_read = 1; i_at = -1; d_at = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) chk("t3_first_addr", mem_addr, 16'h0080);
      if (d_done) begin
        d_at = k;
        chk("t3_d_rdata", d_rdata, 64'h5555_6666_7777_8888);
        mem_rdata = 64'h9999_AAAA_BBBB_CCCC;
      end
      if (d_at > 0 && k == d_at + 1) d_read = 0;
      if (d_at > 0 && k == d_at + 2) chk("t3_second_addr", mem_addr, 16'h0040);
      if (i_done) begin i_at = k; break; end
    end
    chk("t3_d_done_at", d_at, 5);
    chk("t3_spacing", i_at - d_at, 6);
    chk("t3_i_rdata", i_rdata, 64'h9999_AAAA_BBBB_CCCC);
    i_read = 0;
    step();

    // 2: D write-back; requester changes inputs after grant
    d_write = 1; d_addr = 16'h0102; d_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk("t2_grant_write", mem_write, 1);
    chk("t2_grant_addr", mem_addr, 16'h0100);
    d_wdata = 64'h0123_4567_89AB_CDEF; d_addr = 16'h0000;
    run_access(20, rd_n, wr_n, i_at, d_at, addr_seen, unstable);
    chk("t2_wr_cycles", wr_n, 3);
    chk("t2_rd_cycles", rd_n, 0);
    chk("t2_done_at", d_at, 4);
    chk("t2_addr", addr_seen, 16'h0100);
    chk("t2_stable", unstable, 0);
    chk("t2_wdata", mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("t2_d_rdata_kept", d_rdata, 64'h5555_6666_7777_8888);
    d_write = 0;
    step();

    // 4: read+write together is a write
    d_read = 1; d_write = 1; d_addr = 16'h0203; d_wdata = 64'h1234_5678_9ABC_DEF0;
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    run_access(20, rd_n, wr_n, i_at, d_at, addr_seen, unstable);
    chk("t4_rd_cycles", rd_n, 0);
    chk("t4_wr_cycles", wr_n, 4);
    chk("t4_done_at", d_at, 5);
    chk("t4_addr", addr_seen, 16'h0200);
    chk("t4_wdata", mem_wdata, 64'h1234_5678_9ABC_DEF0);
    chk("t4_d_rdata_kept", d_rdata, 64'h5555_6666_7777_8888);
    d_read = 0; d_write = 0;
    step();

    // 5: reset at count=2 aborts the access
    i_read = 1; i_addr = 16'h0333; mem_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    step(); step();
    chk("t5_pre_rst_read", mem_read, 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_drop", mem_read, 0);
    chk("t5_rst_i_rdata", i_rdata, 0);
    chk("t5_rst_addr", mem_addr, 0);
    step();
    chk("t5_no_done", i_done, 0);
    step();
    reset = 1'b0;
    run_access(20, rd_n, wr_n, i_at, d_at, addr_seen, unstable);
    chk("t5_rd_cycles", rd_n, 4);
    chk("t5_done_at", i_at, 5);
    chk("t5_addr", addr_seen, 16'h0330);
    chk("t5_i_rdata", i_rdata, 64'h0F0F_0F0F_0F0F_0F0F);

    // 6: request held through done, dropped in the cycle after
    step();
    chk("t6_idle_read", mem_read, 0);
    chk("t6_idle_done", i_done, 0);
    i_read = 0;
    extra_rd = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (mem_read || mem_write) extra_rd++;
    end
    chk("t6_no_reissue", extra_rd, 0);
    chk("both_done_never", both_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
